// File: rtl/fp_sub_seq.sv
// Sequential single-precision subtractor: out = src1 - src2.
// Walks IDLE -> ALIGN -> SUB -> NORM -> ROUND -> DONE with a valid/ready handshake on both sides.
module fp_sub_seq (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out,
  output logic        out_valid,
  input  logic        out_ready
);

  typedef enum logic [2:0] {IDLE, ALIGN, SUB, NORM, ROUND, DONE} state_t;

  state_t      state;
  logic [31:0] a_reg;
  logic [31:0] b_reg;
  logic [26:0] m_big;
  logic [26:0] m_small;
  logic        s_big;
  logic        s_small;
  logic        inf_flag;
  logic        sign_r;
  logic [9:0]  exp_w;
  logic [27:0] mag;

  logic [7:0]  ea, eb, e_big, e_small, d;
  logic [26:0] sig_a, sig_b, big_sig, small_sig, lost, small_al;
  logic        a_ge_b, any_inf, sb_big, sb_small;

  logic        inc;
  logic [24:0] rsum;
  logic [23:0] sig_r;
  logic [9:0]  exp_r;
  logic [31:0] packed_res;

  // Operand unpack, ordering by magnitude and sticky right-shift of the smaller significand
  always_comb begin
    ea       = (a_reg[30:23] == 8'd0) ? 8'd1 : a_reg[30:23];
    eb       = (b_reg[30:23] == 8'd0) ? 8'd1 : b_reg[30:23];
    sig_a    = {|a_reg[30:23], a_reg[22:0], 3'b000};
    sig_b    = {|b_reg[30:23], b_reg[22:0], 3'b000};
    a_ge_b   = (a_reg[30:0] >= b_reg[30:0]);
    any_inf  = (a_reg[30:23] == 8'hFF) || (b_reg[30:23] == 8'hFF);
    if (a_ge_b) begin
      big_sig   = sig_a;
      small_sig = sig_b;
      e_big     = ea;
      e_small   = eb;
      sb_big    = a_reg[31];
      sb_small  = b_reg[31];
    end else begin
      big_sig   = sig_b;
      small_sig = sig_a;
      e_big     = eb;
      e_small   = ea;
      sb_big    = b_reg[31];
      sb_small  = a_reg[31];
    end
    d    = e_big - e_small;
    lost = '0;
    if (d >= 8'd26) begin
      small_al = {26'd0, |small_sig};
    end else begin
      lost     = small_sig & ~({27{1'b1}} << d);
      small_al = (small_sig >> d) | {26'd0, |lost};
    end
  end

  // Round-to-nearest-even on the normalised magnitude and final packing
  always_comb begin
    inc   = mag[2] & (mag[3] | mag[1] | mag[0]);
    rsum  = {1'b0, mag[26:3]} + {24'd0, inc};
    if (rsum[24]) begin
      sig_r = rsum[24:1];
      exp_r = exp_w + 10'd1;
    end else begin
      sig_r = rsum[23:0];
      exp_r = exp_w;
    end
    if (inf_flag)
      packed_res = {s_big, 8'hFF, 23'd0};
    else if (mag == 28'd0)
      packed_res = '0;
    else if (exp_r >= 10'd255)
      packed_res = {sign_r, 8'hFF, 23'd0};
    else if (!sig_r[23])
      packed_res = {sign_r, 8'd0, sig_r[22:0]};
    else
      packed_res = {sign_r, exp_r[7:0], sig_r[22:0]};
  end

  // Control FSM with registered handshake outputs and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out       <= '0;
      out_valid <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      m_big     <= '0;
      m_small   <= '0;
      s_big     <= 1'b0;
      s_small   <= 1'b0;
      inf_flag  <= 1'b0;
      sign_r    <= 1'b0;
      exp_w     <= '0;
      mag       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= src1;
            b_reg    <= {~src2[31], src2[30:0]};
            in_ready <= 1'b0;
            state    <= ALIGN;
          end
        end
        ALIGN: begin
          m_big    <= big_sig;
          m_small  <= small_al;
          s_big    <= sb_big;
          s_small  <= sb_small;
          exp_w    <= {2'b00, e_big};
          inf_flag <= any_inf;
          state    <= SUB;
        end
        SUB: begin
          if (s_big == s_small) begin
            mag    <= {1'b0, m_big} + {1'b0, m_small};
            sign_r <= s_big;
          end else begin
            mag    <= {1'b0, m_big - m_small};
            sign_r <= (m_big == m_small) ? 1'b0 : s_big;
          end
          state <= NORM;
        end
        NORM: begin
          // Each shifting cycle also decides whether it was the last one,
          // so the cycle count equals the shift count (minimum one).
          if (inf_flag || mag == 28'd0) begin
            state <= ROUND;
          end else if (mag[27]) begin
            mag   <= {1'b0, mag[27:2], mag[1] | mag[0]};
            exp_w <= exp_w + 10'd1;
            state <= ROUND;
          end else if (mag[26] || exp_w == 10'd1) begin
            state <= ROUND;
          end else begin
            mag   <= mag << 1;
            exp_w <= exp_w - 10'd1;
            if (mag[25] || exp_w == 10'd2)
              state <= ROUND;
          end
        end
        ROUND: begin
          out       <= packed_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_sub_seq.sv
// Scoreboard bench for fp_sub_seq: driver pushes expected results, monitor pops on each new out_valid.
module tb_fp_sub_seq;

  logic        clk;
  logic        rst;
  logic [31:0] src1;
  logic [31:0] src2;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out;
  logic        out_valid;
  logic        out_ready;

  typedef struct {
    logic [31:0] res;
    int          lat;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   accept_cyc = 0;
  logic prev_v = 1'b0;

  logic [31:0] va[14];
  logic [31:0] vb[14];
  logic [31:0] vr[14];
  int          vl[14];

  fp_sub_seq dut (
    .clk(clk),
    .rst(rst),
    .src1(src1),
    .src2(src2),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out(out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] res, input int lat, input bit push);
    int n;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      checks++;
      errors++;
      $display("FAIL in_ready_timeout got=%0b want=1", in_ready);
    end
    src1     = a;
    src2     = b;
    in_valid = 1'b1;
    if (push) sb.push_back('{res, lat});
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    in_valid   = 1'b0;
    src1       = 32'hDEADBEEF;
    src2       = 32'h12345678;
  endtask

  // Monitor: compare result and inclusive accept-to-valid edge count on each new result
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result got=%h want=none", out);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check_val("result", out, e.res);
          check_val("latency", cyc - accept_cyc + 1, e.lat);
        end
      end
      prev_v = out_valid;
    end
  end

  initial begin
    logic [31:0] hold;
    int          n;
    bit          seen;

    va = '{32'h40400000, 32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h7F7FFFFF,
           32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h00000002, 32'h7F800000,
           32'h3F800000, 32'h3F800000, 32'h3F800000, 32'h3FC00000};
    vb = '{32'h3F800000, 32'h3F800000, 32'hBF800000, 32'h3F7FFFFF, 32'hFF7FFFFF,
           32'h33800000, 32'hB3800000, 32'hB3C00000, 32'h00000001, 32'h3F800000,
           32'h7F800000, 32'h30800000, 32'h40400000, 32'h3FA00000};
    vr = '{32'h40000000, 32'h00000000, 32'h40000000, 32'h33800000, 32'h7F800000,
           32'h3F7FFFFF, 32'h3F800000, 32'h3F800001, 32'h00000001, 32'h7F800000,
           32'hFF800000, 32'h3F800000, 32'hC0000000, 32'h3E800000};
    vl = '{5, 5, 5, 28, 5, 5, 5, 5, 5, 5, 5, 5, 5, 6};

    rst       = 1'b1;
    in_valid  = 1'b0;
    src1      = '0;
    src2      = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_out", out, 32'h0);
    check_val("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("rst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;

    // Consumer stall: hold out_ready low for three cycles in DONE
    out_ready = 1'b0;
    issue(va[0], vb[0], vr[0], vl[0], 1'b1);
    n = 0;
    while (!out_valid && n < 60) begin
      @(posedge clk);
      #1;
      n++;
    end
    check_val("stall_reach_valid", {31'd0, out_valid}, 32'd1);
    hold = out;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_val("stall_out", out, hold);
      check_val("stall_out_valid", {31'd0, out_valid}, 32'd1);
      check_val("stall_in_ready", {31'd0, in_ready}, 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;

    for (int i = 1; i < 14; i++)
      issue(va[i], vb[i], vr[i], vl[i], 1'b1);

    n = 0;
    @(negedge clk);
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end

    // Reset in the middle of a long NORM phase discards the operation
    issue(va[3], vb[3], vr[3], vl[3], 1'b0);
    repeat (6) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check_val("midrst_out_valid", {31'd0, out_valid}, 32'd0);
    check_val("midrst_out", out, 32'h0);
    check_val("midrst_in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    check_val("midrst_no_result", {31'd0, seen}, 32'd0);

    check_val("scoreboard_empty", sb.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_sub_seq.md
FP_SUB_SEQ -- requirements
Module: fp_sub_seq

Interface
REQ-001 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: synchronous, active-high reset, sampled on the rising edge of clk.
REQ-003 SHALL have port src1, input, 32 bits: IEEE-754 single-precision minuend.
REQ-004 SHALL have port src2, input, 32 bits: IEEE-754 single-precision subtrahend.
REQ-005 SHALL have port in_valid, input, 1 bit: src1 and src2 hold a valid operand pair.
REQ-006 SHALL have port in_ready, output, 1 bit: the block can accept an operand pair.
REQ-007 SHALL have port out, output, 32 bits: single-precision result of src1 - src2.
REQ-008 SHALL have port out_valid, output, 1 bit: out holds a completed result.
REQ-009 SHALL have port out_ready, input, 1 bit: the consumer accepts out.

Function
REQ-010 SHALL use the FSM states IDLE, ALIGN, SUB, NORM, ROUND and DONE, in that order of flow.
REQ-011 SHALL drive in_ready = 1 only in IDLE.
REQ-012 SHALL, in IDLE with in_valid = 1, register src1 and src2 with src2's sign inverted, then move to ALIGN; src1 and src2 are ignored at all other times.
REQ-013 SHALL treat an operand with exponent 0 as exponent 1 with hidden bit 0, and any other operand as hidden bit 1.
REQ-014 SHALL, in ALIGN (one cycle), right-shift the smaller-exponent significand by the exponent difference in a working field of at least 27 bits (hidden bit, 23 fraction bits, guard, round, sticky); bits shifted out OR into sticky; a difference of 26 or more leaves only sticky.
REQ-015 SHALL, in SUB (one cycle), on equal effective signs add magnitudes and keep that sign.
REQ-016 SHALL, in SUB, on unequal effective signs subtract the smaller magnitude from the larger and take the sign of the larger; on equal magnitudes the sign is +.
REQ-017 SHALL, in NORM, on a carry-out perform one right shift (sticky preserved) with exponent + 1, and take one cycle.
REQ-018 SHALL, in NORM otherwise, shift left one bit per cycle with exponent - 1 until the hidden bit is 1 or the exponent reaches 1; the NORM cycle count is max(1, shifts).
REQ-019 SHALL, in NORM, skip shifting and go to ROUND when the magnitude is zero.
REQ-020 SHALL, in ROUND (one cycle), round to nearest, ties to even: increment if guard AND (lsb OR round OR sticky).
REQ-021 SHALL, on a rounding carry, shift right by one and increment the exponent in the same cycle.
REQ-022 SHALL, at the end of ROUND, set out to +0 (0x00000000) for a zero magnitude, to exponent 0 when the hidden bit is 0 (denormal), and otherwise pack {sign, exponent, fraction}.
REQ-023 SHALL, when the exponent reaches 255, produce infinity {sign, 0xFF, 23'd0}.
REQ-024 SHALL treat any input with exponent 255 as infinity; an operand pair with exponent 255 SHALL yield out = the infinity of the larger-magnitude operand's effective sign; NaN is not propagated.
REQ-025 SHALL, in DONE, hold out_valid = 1 with out stable until out_ready = 1, then return to IDLE on that edge; back-to-back acceptance is not permitted (in_ready = 0 in DONE).
REQ-026 SHALL have a latency from the accept edge to out_valid of 4 + (NORM cycles) edges; minimum 5 edges, maximum 5 + 23 = 28 edges.

Reset
REQ-027 SHALL, on rst = 1, go to IDLE and clear out = 0x00000000, out_valid = 0 and in_ready = 1 (from the next cycle).
REQ-028 SHALL let rst take priority over every state, including mid-NORM and DONE with out_ready low; an in-flight operation is discarded and produces no result.

Verification
REQ-029 SHALL cover: src1 = 0x40400000 (3.0), src2 = 0x3F800000 -> out = 0x40000000, out_valid 5 edges after accept.
REQ-030 SHALL cover: src1 = 0x3F800000, src2 = 0x3F800000 -> out = 0x00000000 (+0), out_valid 5 edges after accept.
REQ-031 SHALL cover: src1 = 0x3F800000, src2 = 0xBF800000 -> out = 0x40000000 (carry path).
REQ-032 SHALL cover: src1 = 0x3F800000, src2 = 0x3F7FFFFF -> out = 0x33800000 (2^-24), out_valid 28 edges after accept (24 left shifts, 23 above the minimum).
REQ-033 SHALL cover: src1 = 0x7F7FFFFF, src2 = 0xFF7FFFFF -> out = 0x7F800000 (overflow to +inf).
REQ-034 SHALL cover: out_ready held low 3 cycles in DONE -> out and out_valid stable and in_ready = 0; rst asserted mid-NORM -> next cycle out_valid = 0, out = 0, in_ready = 1.
